// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    // Start, parity and stop wrap the payload.
    localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Byte handshake and status bundle between the PS/2 receiver and its consumer.
interface ps2_kbd_rx_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] data_o;
    logic                     parity_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     frame_err_o;
    logic                     parity_err_o;
    logic                     overrun_o;
    logic                     err_clr_i;
    logic                     busy_o;

    modport master (
        output data_o, parity_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
        input  ready_i, err_clr_i
    );

    modport slave (
        input  data_o, parity_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
        output ready_i, err_clr_i
    );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus stability filter for one PS/2 line, with a falling-edge strobe.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            // Any sample matching the current level restarts the stability count.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_filt <= r_sync2;
                r_fall <= ~r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_filt;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver on the system clock: frame decode, error flags, one-byte holding.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned TO_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ps2_clk_i,
    input  logic                ps2_dat_i,
    ps2_kbd_rx_if.master        bus
);
    localparam int unsigned BC_W = $clog2(PS2_DATA_BITS);

    logic w_clk_level_unused;
    logic w_fe;
    logic w_dat;
    logic w_dat_fall_unused;
    logic w_accept;

    ps2_state_e               r_state;
    logic [BC_W-1:0]          r_bitcnt;
    logic [PS2_DATA_BITS-1:0] r_sh;
    logic                     r_p;
    logic [TO_W-1:0]          r_to;
    logic [PS2_DATA_BITS-1:0] r_data;
    logic                     r_parity;
    logic                     r_valid;
    logic                     r_ferr;
    logic                     r_perr;
    logic                     r_ovr;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (ps2_clk_i),
        .o_level (w_clk_level_unused),
        .o_fall  (w_fe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (ps2_dat_i),
        .o_level (w_dat),
        .o_fall  (w_dat_fall_unused)
    );

    assign w_accept = r_valid & bus.ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_sh     <= '0;
            r_p      <= 1'b0;
            r_to     <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            // Clear first so an error raised below in the same cycle wins.
            if (bus.err_clr_i) begin
                r_ferr <= 1'b0;
                r_perr <= 1'b0;
                r_ovr  <= 1'b0;
            end

            if (!en) begin
                r_state  <= IDLE;
                r_to     <= '0;
                r_sh     <= '0;
                r_bitcnt <= '0;
            end else if (w_fe) begin
                r_to <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_dat) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                            r_sh     <= '0;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_sh     <= {w_dat, r_sh[PS2_DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == BC_W'(PS2_DATA_BITS - 1)) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_p     <= w_dat;
                        r_state <= STOP;
                    end
                    STOP: begin
                        if (!w_dat) begin
                            r_ferr <= 1'b1;
                        end else if (!odd_parity_ok(r_sh, r_p)) begin
                            r_perr <= 1'b1;
                        end else if (r_valid && !bus.ready_i) begin
                            r_ovr <= 1'b1;
                        end else begin
                            r_data   <= r_sh;
                            r_parity <= r_p;
                            r_valid  <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_to == TO_W'(TIMEOUT - 1)) begin
                    r_ferr   <= 1'b1;
                    r_state  <= IDLE;
                    r_sh     <= '0;
                    r_bitcnt <= '0;
                    r_to     <= '0;
                end else begin
                    r_to <= r_to + 1'b1;
                end
            end else begin
                r_to <= '0;
            end
        end
    end

    assign bus.data_o       = r_data;
    assign bus.parity_o     = r_parity;
    assign bus.valid_o      = r_valid;
    assign bus.frame_err_o  = r_ferr;
    assign bus.parity_err_o = r_perr;
    assign bus.overrun_o    = r_ovr;
    assign bus.busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx driving 40/40-clock PS/2 bit cells.
module tb_ps2_kbd_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic ps2_clk;
    logic ps2_dat;

    int n_checks = 0;
    int n_errors = 0;

    int         acc_cnt = 0;
    logic [7:0] acc_data [0:7];

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(
        .FILTER_LEN (4),
        .TIMEOUT    (500),
        .TO_W       (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.valid_o && bus.ready_i) begin
            acc_data[acc_cnt[2:0]] <= bus.data_o;
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_clks(20);
        ps2_clk = 1'b0;
        wait_clks(40);
        ps2_clk = 1'b1;
        wait_clks(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ pflip);
        send_bit(stop);
        ps2_dat = 1'b1;
        wait_clks(5);
    endtask

    task automatic clear_errs();
        bus.err_clr_i = 1'b1;
        wait_clks(1);
        bus.err_clr_i = 1'b0;
        wait_clks(1);
    endtask

    task automatic accept_one();
        bus.ready_i = 1'b1;
        wait_clks(1);
        bus.ready_i = 1'b0;
    endtask

    initial begin
        int acc_before;
        rst_n         = 1'b0;
        en            = 1'b1;
        ps2_clk       = 1'b1;
        ps2_dat       = 1'b1;
        bus.ready_i   = 1'b0;
        bus.err_clr_i = 1'b0;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(5);

        check("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset_data",  {24'd0, bus.data_o}, 32'd0);
        check("reset_flags", {29'd0, bus.frame_err_o, bus.parity_err_o, bus.overrun_o}, 32'd0);
        check("reset_busy",  {31'd0, bus.busy_o}, 32'd0);

        // Good frame 0x1C, odd parity bit 0.
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_valid",  {31'd0, bus.valid_o}, 32'd1);
        check("t1_data",   {24'd0, bus.data_o}, 32'h1C);
        check("t1_parity", {31'd0, bus.parity_o}, 32'd0);
        check("t1_flags",  {29'd0, bus.frame_err_o, bus.parity_err_o, bus.overrun_o}, 32'd0);
        check("t1_busy",   {31'd0, bus.busy_o}, 32'd0);
        accept_one();
        check("t1_accept", {31'd0, bus.valid_o}, 32'd0);

        // Parity bit inverted.
        send_frame(8'hF0, 1'b1, 1'b1);
        check("t2_perr",  {31'd0, bus.parity_err_o}, 32'd1);
        check("t2_valid", {31'd0, bus.valid_o}, 32'd0);
        clear_errs();
        check("t2_clr",   {31'd0, bus.parity_err_o}, 32'd0);

        // Overrun: second good frame while first is still held.
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1);
        check("t3_data",    {24'd0, bus.data_o}, 32'h12);
        check("t3_parity",  {31'd0, bus.parity_o}, 32'd1);
        check("t3_overrun", {31'd0, bus.overrun_o}, 32'd1);
        check("t3_valid",   {31'd0, bus.valid_o}, 32'd1);
        accept_one();
        check("t3_accept",  {31'd0, bus.valid_o}, 32'd0);
        clear_errs();
        check("t3_clr",     {31'd0, bus.overrun_o}, 32'd0);

        // Bad stop bit.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t4_stop_ferr",  {31'd0, bus.frame_err_o}, 32'd1);
        check("t4_stop_valid", {31'd0, bus.valid_o}, 32'd0);
        clear_errs();

        // Frame abandoned after 6 falling edges, then timeout.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t4_partial_busy", {31'd0, bus.busy_o}, 32'd1);
        check("t4_partial_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        wait_clks(600);
        check("t4_to_ferr", {31'd0, bus.frame_err_o}, 32'd1);
        check("t4_to_busy", {31'd0, bus.busy_o}, 32'd0);
        clear_errs();
        send_frame(8'h5A, 1'b0, 1'b1);
        check("t4_resync_valid", {31'd0, bus.valid_o}, 32'd1);
        check("t4_resync_data",  {24'd0, bus.data_o}, 32'h5A);
        check("t4_resync_flags", {29'd0, bus.frame_err_o, bus.parity_err_o, bus.overrun_o}, 32'd0);
        accept_one();

        // Two-clock glitch on the PS/2 clock while idle.
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(20);
        check("t5_glitch_busy", {31'd0, bus.busy_o}, 32'd0);
        check("t5_glitch_ferr", {31'd0, bus.frame_err_o}, 32'd0);

        // Reset in the middle of a frame with a byte held.
        send_frame(8'h1C, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t5_pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("t5_rst_data",  {24'd0, bus.data_o}, 32'd0);
        check("t5_rst_busy",  {31'd0, bus.busy_o}, 32'd0);
        check("t5_rst_flags", {28'd0, bus.parity_o, bus.frame_err_o, bus.parity_err_o,
                               bus.overrun_o}, 32'd0);
        ps2_dat = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(5);

        // Back-to-back frames with ready held high.
        acc_before  = acc_cnt;
        bus.ready_i = 1'b1;
        send_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        bus.ready_i = 1'b0;
        wait_clks(2);
        check("t6_accepts", acc_cnt - acc_before, 32'd2);
        check("t6_first",   {24'd0, acc_data[acc_before[2:0]]}, 32'hAA);
        check("t6_second",  {24'd0, acc_data[3'(acc_before + 1)]}, 32'h55);
        check("t6_overrun", {31'd0, bus.overrun_o}, 32'd0);
        check("t6_valid",   {31'd0, bus.valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
